// File: rtl/fadd_shift_arbiter_pkg.sv
// Shared constants and direction encoding for the FP adder shift arbiter.
// SHIFT_STICKY_EN (optional define) builds the right-shift sticky logic.
package fadd_shift_arbiter_pkg;

  localparam int W_DEF  = 11;
  localparam int SW_DEF = 5;
  localparam int TW_DEF = 2;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

endpackage

// File: rtl/fadd_shift_arbiter_shift_unit.sv
// Combinational 11-bit shifter: right shift for alignment, left for normalization.
// Sticky (OR of bits lost by a right shift) exists only when SHIFT_STICKY_EN is defined.
module shift_unit_11bit
  import fadd_shift_arbiter_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [W:1]  data,
  input  logic [SW:1] amt,
  input  dir_t        dir,
  output logic [W:1]  shifted,
  output logic        sticky
);

  logic [W:1] right_res;
  logic [W:1] left_res;

  // Amounts of W or more naturally shift everything out, giving zero.
  assign right_res = data >> amt;
  assign left_res  = data << amt;
  assign shifted   = (dir == DIR_LEFT) ? left_res : right_res;

`ifdef SHIFT_STICKY_EN
  logic [W:1] lost_mask;

  // Ones in the positions a right shift by amt discards.
  assign lost_mask = ~({W{1'b1}} << amt);
  assign sticky    = (dir == DIR_RIGHT) && (|(data & lost_mask));
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: rtl/fadd_shift_arbiter.sv
// Round-robin arbiter sharing one shift unit between alignment and normalization,
// with a one-deep registered result. SHIFT_STICKY_EN enables res_sticky.
module fadd_shift_arbiter
  import fadd_shift_arbiter_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          al_valid,
  output logic          al_ready,
  input  logic [W:1]    al_data,
  input  logic [SW:1]   al_amt,
  input  logic [TW:1]   al_tag,
  input  logic          nm_valid,
  output logic          nm_ready,
  input  logic [W:1]    nm_data,
  input  logic [SW:1]   nm_amt,
  input  logic [TW:1]   nm_tag,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W:1]    res_data,
  output logic          res_dir,
  output logic [TW:1]   res_tag,
  output logic          res_sticky
);

  dir_t        last_grant;
  dir_t        sel_dir;
  logic        slot_free;
  logic        grant_al;
  logic        grant_nm;
  logic [W:1]  sel_data;
  logic [SW:1] sel_amt;
  logic [TW:1] sel_tag;
  logic [W:1]  shifted;
  logic        sticky;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    slot_free = !res_valid || res_ready;
    grant_al  = !reset && slot_free && al_valid && (!nm_valid || last_grant == DIR_LEFT);
    grant_nm  = !reset && slot_free && nm_valid && (!al_valid || last_grant == DIR_RIGHT);
    sel_dir   = grant_nm ? DIR_LEFT : DIR_RIGHT;
    sel_data  = grant_nm ? nm_data : al_data;
    sel_amt   = grant_nm ? nm_amt : al_amt;
    sel_tag   = grant_nm ? nm_tag : al_tag;
  end

  assign al_ready = grant_al;
  assign nm_ready = grant_nm;

  shift_unit_11bit #(
    .W  (W),
    .SW (SW)
  ) u_shift (
    .data    (sel_data),
    .amt     (sel_amt),
    .dir     (sel_dir),
    .shifted (shifted),
    .sticky  (sticky)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_dir    <= DIR_RIGHT;
      res_tag    <= '0;
      res_sticky <= 1'b0;
      last_grant <= DIR_LEFT;
    end else if (grant_al || grant_nm) begin
      res_valid  <= 1'b1;
      res_data   <= shifted;
      res_dir    <= sel_dir;
      res_tag    <= sel_tag;
      res_sticky <= sticky;
      last_grant <= sel_dir;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fadd_shift_arbiter.sv
// Randomized self-checking bench for fadd_shift_arbiter against an arithmetic model.
// Honors SHIFT_STICKY_EN for the expected sticky value.
module tb_fadd_shift_arbiter;

  localparam int W  = 11;
  localparam int SW = 5;
  localparam int TW = 2;

  logic          clk;
  logic          reset;
  logic          al_valid, al_ready, nm_valid, nm_ready;
  logic [W:1]    al_data, nm_data;
  logic [SW:1]   al_amt, nm_amt;
  logic [TW:1]   al_tag, nm_tag;
  logic          res_valid, res_ready, res_dir, res_sticky;
  logic [W:1]    res_data;
  logic [TW:1]   res_tag;

  int total = 0;
  int bad   = 0;

  // Model of the result slot and of who won the previous arbitration.
  bit m_valid;
  int m_data, m_tag;
  bit m_dir, m_sticky;
  bit m_last_nm;

  fadd_shift_arbiter #(.W(W), .SW(SW), .TW(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .al_valid   (al_valid),
    .al_ready   (al_ready),
    .al_data    (al_data),
    .al_amt     (al_amt),
    .al_tag     (al_tag),
    .nm_valid   (nm_valid),
    .nm_ready   (nm_ready),
    .nm_data    (nm_data),
    .nm_amt     (nm_amt),
    .nm_tag     (nm_tag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_dir    (res_dir),
    .res_tag    (res_tag),
    .res_sticky (res_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: observed=0x%0h required=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Shift as multiplication/division by a power of two.
  task automatic refShift(input int d, input int a, input bit left, output int r, output bit s);
    longint p;
    p = longint'(1) << a;
    if (left) begin
      r = int'((longint'(d) * p) % 2048);
      s = 1'b0;
    end else begin
      r = int'(longint'(d) / p);
`ifdef SHIFT_STICKY_EN
      s = (longint'(d) % p) != 0;
`else
      s = 1'b0;
`endif
    end
  endtask

  // One clock cycle: drive, check readies, advance model, check result register.
  task automatic applyStimulus(input bit av, input int ad, input int aa, input int at,
                               input bit nv, input int nd, input int na, input int nt,
                               input bit rr, output bit ga, output bit gn);
    bit free;
    int r;
    bit s;
    al_valid = av; al_data = W'(ad); al_amt = SW'(aa); al_tag = TW'(at);
    nm_valid = nv; nm_data = W'(nd); nm_amt = SW'(na); nm_tag = TW'(nt);
    res_ready = rr;
    #1;
    free = !m_valid || rr;
    ga = !reset && free && av && (!nv || m_last_nm);
    gn = !reset && free && nv && (!av || !m_last_nm);
    checkOutput("al_ready", al_ready, ga);
    checkOutput("nm_ready", nm_ready, gn);
    if (reset) begin
      m_valid = 0; m_data = 0; m_dir = 0; m_tag = 0; m_sticky = 0; m_last_nm = 1;
    end else if (ga || gn) begin
      if (gn) refShift(nd, na, 1'b1, r, s);
      else    refShift(ad, aa, 1'b0, r, s);
      m_valid = 1; m_data = r; m_sticky = s; m_dir = gn;
      m_tag = gn ? nt : at;
      m_last_nm = gn;
    end else if (rr) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("res_valid", res_valid, m_valid);
    checkOutput("res_data", res_data, m_data);
    checkOutput("res_dir", res_dir, m_dir);
    checkOutput("res_tag", res_tag, m_tag);
    checkOutput("res_sticky", res_sticky, m_sticky);
    @(negedge clk);
  endtask

  bit ga, gn;
  bit cav, cnv;
  int cad, caa, cat, cnd, cna, cnt;

  initial begin
    m_valid = 0; m_data = 0; m_dir = 0; m_tag = 0; m_sticky = 0; m_last_nm = 1;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gn);
    applyStimulus(1, 11'h7FF, 1, 1, 1, 11'h001, 1, 2, 1, ga, gn);
    reset = 1'b0;

    // Tie after reset: alignment first, then alternate.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 11'h400 + i, i, i, 1, 11'h001 + i, i, 3 - i, 1, ga, gn);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gn);

    applyStimulus(1, 11'b10000000001, 3, 1, 0, 0, 0, 0, 1, ga, gn);
    applyStimulus(0, 0, 0, 0, 1, 11'b00000101100, 5, 2, 1, ga, gn);
    applyStimulus(1, 11'h5A5, 0, 0, 0, 0, 0, 0, 1, ga, gn);
    applyStimulus(0, 0, 0, 0, 1, 11'h2C3, 0, 1, 1, ga, gn);
    applyStimulus(1, 11'h7FF, 11, 2, 0, 0, 0, 0, 1, ga, gn);
    applyStimulus(1, 11'h7FF, 31, 3, 0, 0, 0, 0, 1, ga, gn);
    applyStimulus(0, 0, 0, 0, 1, 11'h7FF, 16, 1, 1, ga, gn);
    applyStimulus(1, 11'h7FF, 10, 0, 0, 0, 0, 0, 1, ga, gn);

    // Backpressure: result pending, both requesters waiting.
    applyStimulus(1, 11'h123, 2, 1, 0, 0, 0, 0, 0, ga, gn);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 11'h3F0, 4, 2, 1, 11'h00F, 3, 3, 0, ga, gn);
    applyStimulus(1, 11'h3F0, 4, 2, 1, 11'h00F, 3, 3, 1, ga, gn);
    applyStimulus(1, 11'h3F0, 4, 2, 0, 0, 0, 0, 1, ga, gn);

    // Reset while a result is pending and alignment is requesting.
    applyStimulus(0, 0, 0, 0, 1, 11'h0F0, 2, 1, 0, ga, gn);
    reset = 1'b1;
    applyStimulus(1, 11'h155, 1, 2, 0, 0, 0, 0, 0, ga, gn);
    reset = 1'b0;
    applyStimulus(1, 11'h155, 1, 2, 1, 11'h0AA, 1, 3, 1, ga, gn);

    cav = 0; cnv = 0;
    cad = 0; caa = 0; cat = 0; cnd = 0; cna = 0; cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!cav || ga) begin
        cav = $urandom_range(0, 2) != 0;
        cad = $urandom_range(0, 2047);
        caa = ($urandom_range(0, 3) == 0) ? $urandom_range(11, 31) : $urandom_range(0, 10);
        cat = $urandom_range(0, 3);
      end
      if (!cnv || gn) begin
        cnv = $urandom_range(0, 2) != 0;
        cnd = $urandom_range(0, 2047);
        cna = ($urandom_range(0, 3) == 0) ? $urandom_range(11, 31) : $urandom_range(0, 10);
        cnt = $urandom_range(0, 3);
      end
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus(cav, cad, caa, cat, cnv, cnd, cna, cnt, $urandom_range(0, 3) != 0, ga, gn);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
